micro_sequencer: RTL



---
 rtl/micro_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer for the multicycle MIPS control unit.
// Selects the next control state, tracks stalls, exceptions and retires.
module micro_sequencer #(
   parameter logic [4:0] FETCH_STATE = 5'd0,
   parameter logic [4:0] EXC_STATE   = 5'd31,
   parameter logic [7:0] MAX_WAIT    = 8'd200,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       addr_ctl,
   input  logic [4:0]       next_state_DT1,
   input  logic [4:0]       next_state_DT2,
   input  logic             wait_req,
   input  logic             ext_done,
   input  logic             exc_ack,
   output logic [4:0]       upc,
   output logic [1:0]       exc_cause,
   output logic             instr_retire,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [7:0]       wait_cnt
);

   typedef enum logic [1:0] {
      M_EXC,
      M_STALL,
      M_TIMEOUT,
      M_ADV
   } mode_t;

   localparam logic [1:0] AC_FETCH = 2'b00;
   localparam logic [1:0] AC_DT1   = 2'b01;
   localparam logic [1:0] AC_DT2   = 2'b10;
   localparam logic [1:0] AC_SEQ   = 2'b11;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_UNDEF = 2'b01;
   localparam logic [1:0] CAUSE_TMO   = 2'b10;

   localparam logic [7:0] WAIT_LAST = MAX_WAIT - 8'd1;

   mode_t            mode;
   logic             stall;
   logic [4:0]       tgt;
   logic [4:0]       upc_n;
   logic [1:0]       cause_n;
   logic             ret_n;
   logic [CNT_W-1:0] rcnt_n;
   logic [7:0]       wcnt_n;

   assign stall = wait_req & ~ext_done;

   always_comb begin
      tgt = FETCH_STATE;
      unique case (addr_ctl)
         AC_FETCH: tgt = FETCH_STATE;
         AC_DT1:   tgt = next_state_DT1;
         AC_DT2:   tgt = next_state_DT2;
         AC_SEQ:   tgt = upc + 5'd1;
      endcase
   end

   always_comb begin
      mode = M_ADV;
      if (upc == EXC_STATE)
         mode = M_EXC;
      else if (stall && wait_cnt >= WAIT_LAST)
         mode = M_TIMEOUT;
      else if (stall)
         mode = M_STALL;
   end

   always_comb begin
      upc_n   = upc;
      cause_n = exc_cause;
      ret_n   = 1'b0;
      rcnt_n  = retire_cnt;
      wcnt_n  = wait_cnt;
      unique case (mode)
         M_EXC: begin
            wcnt_n = '0;
            if (exc_ack) begin
               upc_n   = FETCH_STATE;
               cause_n = CAUSE_NONE;
            end
         end
         M_STALL: begin
            wcnt_n = wait_cnt + 8'd1;
         end
         M_TIMEOUT: begin
            upc_n   = EXC_STATE;
            cause_n = CAUSE_TMO;
            wcnt_n  = '0;
         end
         M_ADV: begin
            wcnt_n = '0;
            upc_n  = tgt;
            // A fetch retires; any path landing on EXC_STATE is undefined
            if (addr_ctl == AC_FETCH) begin
               ret_n  = 1'b1;
               rcnt_n = retire_cnt + 1'b1;
            end else if (tgt == EXC_STATE) begin
               cause_n = CAUSE_UNDEF;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         upc          <= FETCH_STATE;
         exc_cause    <= CAUSE_NONE;
         instr_retire <= 1'b0;
         retire_cnt   <= '0;
         wait_cnt     <= '0;
      end else begin
         upc          <= upc_n;
         exc_cause    <= cause_n;
         instr_retire <= ret_n;
         retire_cnt   <= rcnt_n;
         wait_cnt     <= wcnt_n;
      end
   end

endmodule
